// File: rtl/multicycle_control_fsm.sv
// Main control unit for the multicycle MIPS-subset processor.
// Moore sequencer for fetch / decode / execute / memory / write-back, with
// stalls on the shared instruction/data memory handshake (mem_ready).
// Datapath controls decode from the current state. In FETCH, ir_write and
// pc_write also depend on mem_ready, so the IR and PC load only when the
// fetch completes.
// Optional feature macro: ADDI_EN enables the addi path (opcode 0x08 via
// ADDIEXEC/ADDIWB). When it is undefined, opcode 0x08 is illegal and
// encodings 11/12 decode like the unused encodings.
//
// state    | enc | meaning
// ---------+-----+-------------------------------------------------------
// RESET    |  0  | held in reset, all controls off
// FETCH    |  1  | read instruction at PC, PC <- PC+4 when memory ready
// DECODE   |  2  | precompute branch target, dispatch on opcode
// MEMADDR  |  3  | ALU computes load/store address (A + sign-ext imm)
// MEMREAD  |  4  | data memory read at ALUOut, waits for mem_ready
// MEMWB    |  5  | MDR written to rt
// MEMWRITE |  6  | data memory write at ALUOut, waits for mem_ready
// EXECUTE  |  7  | R-type ALU operation (funct decoded)
// ALUWB    |  8  | ALUOut written to rd
// BRANCH   |  9  | compare A-B, PC <- branch target if zero
// JUMP     | 10  | PC <- jump target
// ADDIEXEC | 11  | A + sign-ext imm (ADDI_EN only)
// ADDIWB   | 12  | ALUOut written to rt (ADDI_EN only)
// 13..15   |  -  | unused, controls off, return to FETCH

module multicycle_control_fsm (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADDR  = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECUTE  = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_ADDIEXEC = 4'd11,
        S_ADDIWB   = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    state_e state_q;
    state_e state_d;
    logic   op_legal;

    // Opcode support check used by DECODE for dispatch and illegal_op.
    always_comb begin
        op_legal = 1'b0;
        case (opcode)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J: op_legal = 1'b1;
`ifdef ADDI_EN
            OP_ADDI:                              op_legal = 1'b1;
`endif
            default:                              op_legal = 1'b0;
        endcase
    end

    // Next-state selection; unused encodings fall back to FETCH.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_RESET:    state_d = S_FETCH;
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADDR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
`ifdef ADDI_EN
                    OP_ADDI:      state_d = S_ADDIEXEC;
`endif
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADDR: begin
                if (opcode == OP_LW)      state_d = S_MEMREAD;
                else if (opcode == OP_SW) state_d = S_MEMWRITE;
                else                      state_d = S_FETCH;
            end
            S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTE:  state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
`ifdef ADDI_EN
            S_ADDIEXEC: state_d = S_ADDIWB;
            S_ADDIWB:   state_d = S_FETCH;
`endif
            default:    state_d = S_FETCH;
        endcase
    end

    // State register; reset drops to RESET at once, even mid-stall.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath control decode; anything not set for a state stays 0.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        illegal_op    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b  = 2'b11;
                illegal_op = ~op_legal;
            end
            S_MEMADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMREAD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
`ifdef ADDI_EN
            S_ADDIEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign state = state_q;

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Main control unit of the multicycle MIPS-subset processor. It is a Moore state machine with memory-handshake stalls that sequences fetch, decode, execute, memory and write-back. Each cycle it drives every datapath select and enable, including the 2-bit ALU operand-B source select (00 reg B, 01 constant 4, 10 sign-extended immediate, 11 immediate shifted left 2). It reads the opcode from the instruction register and a ready flag from the shared instruction/data memory.

## Interface
- No parameters.
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- opcode  in  6  instruction register bits [31:26]
- mem_ready  in  1  memory access complete this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero
- i_or_d  out  1  memory address select: 0 PC, 1 ALUOut
- mem_read, mem_write  out  1 each  memory strobes
- ir_write  out  1  instruction register load
- reg_dst  out  1  register write index: 0 rt, 1 rd
- mem_to_reg  out  1  write-back data: 0 ALUOut, 1 MDR
- reg_write  out  1  register file write enable
- alu_src_a  out  1  ALU A source: 0 PC, 1 reg A
- alu_src_b  out  2  ALU B source, encoding as above
- alu_op  out  2  00 add, 01 subtract, 10 funct-decoded
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target
- illegal_op  out  1  one-cycle pulse on an unsupported opcode
- state  out  4  current state, for debug

## Operation
- State encodings: RESET 0, FETCH 1, DECODE 2, MEMADDR 3, MEMREAD 4, MEMWB 5, MEMWRITE 6, EXECUTE 7, ALUWB 8, BRANCH 9, JUMP 10, ADDIEXEC 11, ADDIWB 12.
- Any output not listed for a state is 0.
- RESET: all outputs 0; always moves to FETCH.
- FETCH
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_write are asserted only while mem_ready=1.
  - mem_ready=1 moves to DECODE; mem_ready=0 holds FETCH.
- DECODE
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=00 (precomputes the branch target).
  - Next state by opcode: 0x23 or 0x2B → MEMADDR; 0x00 → EXECUTE; 0x04 → BRANCH; 0x02 → JUMP; 0x08 → ADDIEXEC (see Configuration).
  - Any other opcode → FETCH, with illegal_op=1 for that cycle.
- MEMADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Opcode 0x23 → MEMREAD; 0x2B → MEMWRITE.
- MEMREAD: mem_read=1, i_or_d=1. Holds until mem_ready=1, then → MEMWB.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1; → FETCH.
- MEMWRITE: mem_write=1, i_or_d=1. Holds until mem_ready=1, then → FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10; → ALUWB.
- ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1; → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01; → FETCH.
- JUMP: pc_write=1, pc_source=10; → FETCH.
- ADDIEXEC: alu_src_a=1, alu_src_b=10, alu_op=00; → ADDIWB.
- ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1; → FETCH.
- Unused encodings 13–15: all outputs 0; next state FETCH.

## Timing
- The state register updates on the rising edge of clock.
- reset_n low forces RESET immediately, regardless of clock, and all outputs go to 0. This includes reset asserted during a stalled MEMREAD or MEMWRITE.
- Outputs are combinational from state. Only ir_write and pc_write in FETCH also depend on mem_ready.
- opcode is sampled only in DECODE and MEMADDR. It must be stable from the cycle after FETCH completes.
- Instruction latency with mem_ready held at 1:
  - lw: 5 cycles
  - sw, R-type, addi: 4 cycles
  - beq, j: 3 cycles
  - unsupported opcode: 2 cycles
- Each cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle. While stalled, all outputs hold steady.
- First FETCH occurs on the second rising edge after reset_n deasserts: one edge leaves RESET for FETCH, and fetch completes on the next edge with mem_ready=1.

## Configuration
- ADDI_EN defined: opcode 0x08 follows DECODE → ADDIEXEC → ADDIWB → FETCH.
- ADDI_EN undefined:
  - States 11 and 12 are unreachable and decode as unused (outputs 0, next FETCH).
  - Opcode 0x08 is treated as unsupported: DECODE → FETCH with an illegal_op pulse.

## Test plan
- Reset: hold reset_n=0 for 3 cycles → state=0 and all outputs 0. Release reset_n → state=1 on the next edge.
- lw (opcode 0x23), mem_ready=1 → states 1,2,3,4,5,1. MEMADDR alu_src_b=10; MEMWB reg_write=1 and mem_to_reg=1.
- sw (opcode 0x2B), mem_ready=0 for 3 cycles in MEMWRITE → mem_write=1 and i_or_d=1 for 4 cycles, then state=1.
- beq (opcode 0x04) → DECODE alu_src_b=11; BRANCH alu_op=01, pc_write_cond=1, pc_source=01. j (opcode 0x02) → pc_write=1, pc_source=10.
- Opcode 0x3F → illegal_op high exactly 1 cycle in DECODE, then state=1. Opcode 0x08 → states 11,12 with ADDI_EN defined; illegal_op pulse without it.
- reset_n dropped mid-MEMREAD while stalled → state=0 and mem_read=0 immediately, without waiting for a clock edge.
